fano_cfg_master: RTL and testbench



---
 rtl/fano_regs_pkg.sv | 41 ++++
 rtl/math_pkg.sv | 24 ++
 rtl/fano_cfg_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fano_cfg_master.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fano_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fano_regs_pkg
//  Description : Per-channel register map of the multichannel Fano decoder,
//                address field placement, and the config-master FSM states.
//                Shared between the AXI4-Lite config master and the slave.
//  Revision    : 1.0  initial release
// ============================================================================
package fano_regs_pkg;

   // Register indices within one channel bank
   localparam int unsigned REG_RESET       = 0;
   localparam int unsigned REG_STREAM_SEL  = 1;
   localparam int unsigned REG_CTRL_RESET  = 2;
   localparam int unsigned REG_DIFF_EN     = 3;
   localparam int unsigned REG_MOD         = 4;
   localparam int unsigned REG_CODE_RATE   = 5;
   localparam int unsigned REG_SYNC_PERIOD = 6;
   localparam int unsigned REG_SYNC_THR    = 7;
   localparam int unsigned REG_DELTA_T     = 8;
   localparam int unsigned REG_FWD_STEP    = 9;
   localparam int unsigned REG_SYNC_STAT   = 10;
   localparam int unsigned REG_N_CHS       = 11;

   // Byte-address LSB of the register field, and width of the channel field
   // that sits at the top of the address
   localparam int unsigned ADDR_LSB     = 2;
   localparam int unsigned ADDR_CHS_MUX = 4;

   // Config-master transaction states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_WR_B = 3'd2,
      ST_RD_A = 3'd3,
      ST_RD_R = 3'd4,
      ST_RSP  = 3'd5
   } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/math_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : math_pkg
//  Description : Small elaboration-time arithmetic helpers shared by the
//                decoder control path.
//  Revision    : 1.0  initial release
// ============================================================================
package math_pkg;

   // Ceiling log2: number of bits needed to index 'value' distinct items.
   function automatic int unsigned log2(input int unsigned value);
      int unsigned v;
      int unsigned result;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fano_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module      : fano_cfg_master
//  Description : AXI4-Lite master that turns single register commands
//                (channel, register, data) into exactly one AXI4-Lite write
//                or read on the Fano decoder's per-channel register bank.
//                Illegal commands are refused locally without bus traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module fano_cfg_master
   import fano_regs_pkg::*;
#(
   parameter int N_CHS              = 8,
   parameter int N_REGS             = 12,
   parameter int N_WR_REGS          = 10,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 32
) (
   input  logic                            m_axi_aclk,
   input  logic                            m_axi_areset,
   // command port
   input  logic                            i_cmd_valid,
   output logic                            o_cmd_ready,
   input  logic                            i_cmd_wr,
   input  logic [3:0]                      i_cmd_ch,
   input  logic [3:0]                      i_cmd_reg,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_data,
   // response port
   output logic                            o_rsp_valid,
   input  logic                            i_rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_data,
   output logic [1:0]                      o_rsp_resp,
   output logic                            o_rsp_reject,
   // AXI4-Lite write address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                      m_axi_awprot,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   // AXI4-Lite write data
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   // AXI4-Lite write response
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   // AXI4-Lite read address
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                      m_axi_arprot,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   // AXI4-Lite read data
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready
);

   // Registered state and outputs
   fsm_state_t                        r_state;
   logic                              r_cmd_ready;
   logic                              r_awvalid;
   logic                              r_wvalid;
   logic                              r_bready;
   logic                              r_arvalid;
   logic                              r_rready;
   logic                              r_rsp_valid;
   logic                              r_rsp_reject;
   logic [1:0]                        r_rsp_resp;
   logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_data;
   logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awaddr;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     r_araddr;

   // Next-state values
   fsm_state_t                        w_state_nxt;
   logic                              w_cmd_ready_nxt;
   logic                              w_awvalid_nxt;
   logic                              w_wvalid_nxt;
   logic                              w_bready_nxt;
   logic                              w_arvalid_nxt;
   logic                              w_rready_nxt;
   logic                              w_rsp_valid_nxt;
   logic                              w_rsp_reject_nxt;
   logic [1:0]                        w_rsp_resp_nxt;
   logic [C_M_AXI_DATA_WIDTH-1:0]     w_rsp_data_nxt;
   logic [C_M_AXI_DATA_WIDTH-1:0]     w_wdata_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     w_awaddr_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     w_araddr_nxt;

   logic                              w_cmd_fire;
   logic                              w_reject;
   logic                              w_aw_done;
   logic                              w_w_done;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     w_cmd_addr;

   assign w_cmd_fire = i_cmd_valid && r_cmd_ready;

   // Out-of-range channel or register, or a write to a read-only register
   assign w_reject = (32'(i_cmd_ch)  >= 32'(N_CHS))
                  || (32'(i_cmd_reg) >= 32'(N_REGS))
                  || (i_cmd_wr && (32'(i_cmd_reg) >= 32'(N_WR_REGS)));

   // A write channel counts as done once its valid has already dropped or
   // it handshakes this cycle; AW and W may complete in either order.
   assign w_aw_done = !r_awvalid || m_axi_awready;
   assign w_w_done  = !r_wvalid  || m_axi_wready;

   // Compose the bus address: channel in the top nibble, register at [5:2]
   always_comb begin
      w_cmd_addr = '0;
      w_cmd_addr[C_M_AXI_ADDR_WIDTH-1 -: ADDR_CHS_MUX] = i_cmd_ch;
      w_cmd_addr[ADDR_LSB +: 4]                        = i_cmd_reg;
   end

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      w_state_nxt      = r_state;
      w_cmd_ready_nxt  = r_cmd_ready;
      w_awvalid_nxt    = r_awvalid;
      w_wvalid_nxt     = r_wvalid;
      w_bready_nxt     = r_bready;
      w_arvalid_nxt    = r_arvalid;
      w_rready_nxt     = r_rready;
      w_rsp_valid_nxt  = r_rsp_valid;
      w_rsp_reject_nxt = r_rsp_reject;
      w_rsp_resp_nxt   = r_rsp_resp;
      w_rsp_data_nxt   = r_rsp_data;
      w_wdata_nxt      = r_wdata;
      w_awaddr_nxt     = r_awaddr;
      w_araddr_nxt     = r_araddr;

      case (r_state)
         ST_IDLE: begin
            w_cmd_ready_nxt = 1'b1;
            if (w_cmd_fire) begin
               w_cmd_ready_nxt = 1'b0;
               if (w_reject) begin
                  w_state_nxt      = ST_RSP;
                  w_rsp_valid_nxt  = 1'b1;
                  w_rsp_reject_nxt = 1'b1;
                  w_rsp_resp_nxt   = 2'b00;
                  w_rsp_data_nxt   = '0;
               end else if (i_cmd_wr) begin
                  w_state_nxt   = ST_WR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
                  w_awaddr_nxt  = w_cmd_addr;
                  w_wdata_nxt   = i_cmd_data;
               end else begin
                  w_state_nxt   = ST_RD_A;
                  w_arvalid_nxt = 1'b1;
                  w_araddr_nxt  = w_cmd_addr;
               end
            end
         end
         ST_WR: begin
            if (m_axi_awready) begin
               w_awvalid_nxt = 1'b0;
            end
            if (m_axi_wready) begin
               w_wvalid_nxt = 1'b0;
            end
            if (w_aw_done && w_w_done) begin
               w_state_nxt  = ST_WR_B;
               w_bready_nxt = 1'b1;
            end
         end
         ST_WR_B: begin
            if (m_axi_bvalid) begin
               w_state_nxt      = ST_RSP;
               w_bready_nxt     = 1'b0;
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_reject_nxt = 1'b0;
               w_rsp_resp_nxt   = m_axi_bresp;
               w_rsp_data_nxt   = '0;
            end
         end
         ST_RD_A: begin
            if (m_axi_arready) begin
               w_state_nxt   = ST_RD_R;
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
            end
         end
         ST_RD_R: begin
            if (m_axi_rvalid) begin
               w_state_nxt      = ST_RSP;
               w_rready_nxt     = 1'b0;
               w_rsp_valid_nxt  = 1'b1;
               w_rsp_reject_nxt = 1'b0;
               w_rsp_resp_nxt   = m_axi_rresp;
               w_rsp_data_nxt   = m_axi_rdata;
            end
         end
         ST_RSP: begin
            if (i_rsp_ready) begin
               w_state_nxt     = ST_IDLE;
               w_rsp_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
      if (m_axi_areset) begin
         r_state      <= ST_IDLE;
         r_cmd_ready  <= 1'b0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_reject <= 1'b0;
         r_rsp_resp   <= 2'b00;
         r_rsp_data   <= '0;
         r_wdata      <= '0;
         r_awaddr     <= '0;
         r_araddr     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cmd_ready  <= w_cmd_ready_nxt;
         r_awvalid    <= w_awvalid_nxt;
         r_wvalid     <= w_wvalid_nxt;
         r_bready     <= w_bready_nxt;
         r_arvalid    <= w_arvalid_nxt;
         r_rready     <= w_rready_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_reject <= w_rsp_reject_nxt;
         r_rsp_resp   <= w_rsp_resp_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_wdata      <= w_wdata_nxt;
         r_awaddr     <= w_awaddr_nxt;
         r_araddr     <= w_araddr_nxt;
      end
   end

   assign o_cmd_ready   = r_cmd_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_data    = r_rsp_data;
   assign o_rsp_resp    = r_rsp_resp;
   assign o_rsp_reject  = r_rsp_reject;

   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_fano_cfg_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fano_cfg_master
//  Description : Self-checking bench for fano_cfg_master with a reactive
//                AXI4-Lite slave and a reference model of the command rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fano_cfg_master;
   import fano_regs_pkg::*;

   localparam int N_CHS     = 8;
   localparam int N_REGS    = 12;
   localparam int N_WR_REGS = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
   logic [3:0]  cmd_ch = '0, cmd_reg = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_reject;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic [31:0] awaddr, wdata, araddr;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
   logic [1:0]  bresp = '0, rresp = '0;
   logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
   logic [31:0] rdata = '0;
   logic        rvalid = 1'b0, rready;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fano_cfg_master #(
      .N_CHS(N_CHS), .N_REGS(N_REGS), .N_WR_REGS(N_WR_REGS),
      .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32)
   ) dut (
      .m_axi_aclk(clk), .m_axi_areset(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
      .i_cmd_ch(cmd_ch), .i_cmd_reg(cmd_reg), .i_cmd_data(cmd_data),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_rsp_resp(rsp_resp), .o_rsp_reject(rsp_reject),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference rules: which commands are refused, and where they land
   function automatic bit ref_reject(input bit wr, input int ch, input int rg);
      return (ch >= N_CHS) || (rg >= N_REGS) || (wr && (rg >= N_WR_REGS));
   endfunction

   function automatic logic [31:0] ref_addr(input int ch, input int rg);
      return 32'(ch) * 32'h1000_0000 + 32'(rg) * 32'd4;
   endfunction

   // One command end to end, with the slave answering after given latencies
   task automatic transact(input bit wr, input int ch, input int rg, input logic [31:0] data,
                           input int aw_lat, input int w_lat, input int b_lat,
                           input int ar_lat, input int r_lat,
                           input logic [1:0] sresp, input logic [31:0] srdata, input int stall);
      bit          rej;
      bit          b_pend, r_pend;
      logic [31:0] exp_addr, exp_data;
      logic [1:0]  exp_resp;
      int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
      int aw_hi = 0, w_hi = 0, ar_hi = 0, b_wait = 0, r_wait = 0;
      int fire_cyc = -1;
      int cyc;
      rej      = ref_reject(wr, ch, rg);
      exp_addr = ref_addr(ch, rg);
      exp_data = (rej || wr) ? 32'd0 : srdata;
      exp_resp = rej ? 2'b00 : sresp;

      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_wr = wr; cmd_ch = 4'(ch); cmd_reg = 4'(rg); cmd_data = data;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = $urandom;
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      cyc = 1;
      while (!rsp_valid && cyc < 200) begin
         chk("awvalid", 32'(awvalid), 32'(wr && !rej && aw_hs == 0));
         chk("wvalid",  32'(wvalid),  32'(wr && !rej && w_hs == 0));
         chk("arvalid", 32'(arvalid), 32'(!wr && !rej && ar_hs == 0));
         chk("bready",  32'(bready),  32'(wr && !rej && aw_hs == 1 && w_hs == 1 && b_hs == 0));
         chk("rready",  32'(rready),  32'(!wr && !rej && ar_hs == 1 && r_hs == 0));
         if (awvalid) begin chk("awaddr", awaddr, exp_addr); chk("awprot", 32'(awprot), 32'd0); end
         if (wvalid)  begin chk("wdata", wdata, data); chk("wstrb", 32'(wstrb), 32'hF); end
         if (arvalid) begin chk("araddr", araddr, exp_addr); chk("arprot", 32'(arprot), 32'd0); end
         b_pend  = (aw_hs == 1 && w_hs == 1 && b_hs == 0);
         r_pend  = (ar_hs == 1 && r_hs == 0);
         awready = awvalid && (aw_hi >= aw_lat);
         wready  = wvalid  && (w_hi  >= w_lat);
         arready = arvalid && (ar_hi >= ar_lat);
         bvalid  = b_pend && (b_wait >= b_lat);
         bresp   = bvalid ? sresp : ~sresp;
         rvalid  = r_pend && (r_wait >= r_lat);
         rresp   = rvalid ? sresp : ~sresp;
         rdata   = rvalid ? srdata : ~srdata;
         if (awvalid && awready) aw_hs++;
         if (wvalid && wready)   w_hs++;
         if (arvalid && arready) ar_hs++;
         if (bvalid && bready) begin b_hs++; fire_cyc = cyc; end
         if (rvalid && rready) begin r_hs++; fire_cyc = cyc; end
         if (awvalid) aw_hi++;
         if (wvalid)  w_hi++;
         if (arvalid) ar_hi++;
         if (b_pend)  b_wait++;
         if (r_pend)  r_wait++;
         @(negedge clk);
         cyc++;
      end
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      chk("rsp_latency", 32'(cyc), rej ? 32'd1 : 32'(fire_cyc + 1));
      chk("aw_held_cycles", 32'(aw_hi), (wr && !rej) ? 32'(aw_lat + 1) : 32'd0);
      chk("aw_count", 32'(aw_hs), 32'(wr && !rej));
      chk("w_count",  32'(w_hs),  32'(wr && !rej));
      chk("b_count",  32'(b_hs),  32'(wr && !rej));
      chk("ar_count", 32'(ar_hs), 32'(!wr && !rej));
      chk("r_count",  32'(r_hs),  32'(!wr && !rej));
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid",  32'(rsp_valid), 32'd1);
         chk("rsp_data",   rsp_data, exp_data);
         chk("rsp_resp",   32'(rsp_resp), 32'(exp_resp));
         chk("rsp_reject", 32'(rsp_reject), 32'(rej));
         chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("rsp_bus_quiet", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
         if (s == stall) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
      chk("reset_rsp", {rsp_data[29:0], rsp_resp}, 32'd0);
      chk("reset_rsp_reject", 32'(rsp_reject), 32'd0);
      chk("reset_awaddr", awaddr, 32'd0);
      chk("reset_araddr", araddr, 32'd0);
      chk("reset_wdata", wdata, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_at_release", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_release", 32'(cmd_ready), 32'd1);

      // Directed steps
      transact(1'b1, 2, REG_SYNC_PERIOD, 32'h0012_3456, 0, 0, 0, 0, 0, 2'b00, 32'd0, 0);
      transact(1'b0, 0, REG_N_CHS, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 2'b00, 32'd8, 0);
      transact(1'b1, 1, REG_SYNC_STAT, 32'hCAFE_0001, 0, 0, 0, 0, 0, 2'b01, 32'd0, 0);
      transact(1'b0, 9, REG_MOD, 32'd0, 0, 0, 0, 0, 0, 2'b11, 32'h5555_AAAA, 0);
      transact(1'b1, 4, REG_DIFF_EN, 32'hA5A5_0F0F, 3, 0, 1, 0, 0, 2'b00, 32'd0, 0);
      transact(1'b1, 7, REG_FWD_STEP, 32'h0000_1234, 0, 2, 0, 0, 0, 2'b10, 32'd0, 1);
      transact(1'b0, 5, REG_SYNC_THR, 32'd0, 0, 0, 0, 0, 2, 2'b10, 32'h1357_9BDF, 5);

      // Reset while a write is waiting on AW/W handshakes
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_ch = 4'd3; cmd_reg = 4'd1; cmd_data = 32'hDEAD_BEEF;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("midwr_awvalid", 32'(awvalid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midwr_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
      chk("midwr_rst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midwr_ready_after_release", 32'(cmd_ready), 32'd1);
      chk("midwr_valids_after", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
      transact(1'b0, 3, REG_STREAM_SEL, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0);

      // Randomized commands
      for (int n = 0; n < 40; n++) begin
         int ch;
         ch = ($urandom_range(0, 4) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
         transact(bit'($urandom_range(0, 1)), ch, int'($urandom_range(0, 15)), $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
